// File: rtl/expr_seq.sv
// Streaming evaluator for "d(+|*)d...=" expressions over ASCII characters.
// '*' binds tighter than '+'; arithmetic wraps at 2^RW; spaces are skipped.
module expr_seq #(
  parameter int unsigned RW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] result,
  output logic          res_err,
  output logic          busy
);

  typedef enum logic [1:0] {StExpNum, StExpOp, StErr, StReport} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] s_q, s_d;
  logic [RW-1:0] t_q, t_d;
  logic          m_q, m_d;
  logic [RW-1:0] result_q, result_d;
  logic          err_q, err_d;
  // Set once a digit has been taken, so busy can tell a fresh EXP_NUM from one after '+'.
  logic          started_q, started_d;

  logic          accept;
  logic          is_space, is_digit, is_plus, is_mul, is_eq;
  logic [RW-1:0] dval;

  always_comb begin
    accept   = in_valid & in_ready;
    is_space = (in_data == 8'h20);
    is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_plus  = (in_data == 8'h2b);
    is_mul   = (in_data == 8'h2a);
    is_eq    = (in_data == 8'h3d);
    dval     = {{(RW-4){1'b0}}, in_data[3:0]};
  end

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StExpNum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StExpNum: begin
        if (accept && !is_space) begin
          if (is_digit)   state_d = StExpOp;
          else if (is_eq) state_d = StReport;
          else            state_d = StErr;
        end
      end
      StExpOp: begin
        if (accept && !is_space) begin
          if (is_plus || is_mul) state_d = StExpNum;
          else if (is_eq)        state_d = StReport;
          else                   state_d = StErr;
        end
      end
      StErr: begin
        if (accept && is_eq) state_d = StReport;
      end
      StReport: begin
        if (res_ready) state_d = StExpNum;
      end
      default: state_d = StExpNum;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s_q       <= '0;
      t_q       <= '0;
      m_q       <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      t_q       <= t_d;
      m_q       <= m_d;
      result_q  <= result_d;
      err_q     <= err_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    s_d       = s_q;
    t_d       = t_q;
    m_d       = m_q;
    result_d  = result_q;
    err_d     = err_q;
    started_d = started_q;
    case (state_q)
      StExpNum: begin
        if (accept && !is_space) begin
          if (is_digit) begin
            t_d       = m_q ? t_q * dval : dval;
            m_d       = 1'b0;
            started_d = 1'b1;
          end else if (is_eq) begin
            result_d = '0;
            err_d    = 1'b1;
          end
        end
      end
      StExpOp: begin
        if (accept && !is_space) begin
          if (is_plus) begin
            s_d = s_q + t_q;
            t_d = '0;
          end else if (is_mul) begin
            m_d = 1'b1;
          end else if (is_eq) begin
            result_d = s_q + t_q;
            err_d    = 1'b0;
          end
        end
      end
      StErr: begin
        if (accept && is_eq) begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      StReport: begin
        if (res_ready) begin
          s_d       = '0;
          t_d       = '0;
          m_d       = 1'b0;
          started_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q != StReport);
    res_valid = (state_q == StReport);
    busy      = (state_q != StExpNum) || started_q;
    result    = result_q;
    res_err   = err_q;
  end

endmodule

// File: tb/tb_expr_seq.sv
// Directed bench for expr_seq: streams ASCII expressions and checks results,
// handshake timing, busy/in_ready behaviour and asynchronous reset.
module tb_expr_seq;

  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] result;
  logic          res_err;
  logic          busy;

  int checks = 0;
  int failures = 0;

  expr_seq #(.RW(RW)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one character from a falling edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] c);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Complete the result handshake and confirm the block leaves REPORT.
  task automatic handshake(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, res_valid, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    // Reset state while clr is held low
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_err", res_err, 0);
    @(negedge clk);
    clr = 1'b1;

    // 2+3*4 = 14, res_ready held high
    res_ready = 1'b1;
    send("2");
    chk("e1_busy_digit", busy, 1);
    send_str("+3*4=");
    chk("e1_valid", res_valid, 1);
    chk("e1_result", result, 14);
    chk("e1_err", res_err, 0);
    chk("e1_in_ready_report", in_ready, 0);
    @(posedge clk);
    #1;
    chk("e1_valid_1cyc", res_valid, 0);
    chk("e1_busy_after", busy, 0);
    chk("e1_result_hold", result, 14);
    res_ready = 1'b0;

    // Leading '+' forces ERR; rest discarded
    send("+");
    chk("e2_err_in_ready", in_ready, 1);
    chk("e2_err_busy", busy, 1);
    send_str("+3*45+3=");
    chk("e2_valid", res_valid, 1);
    chk("e2_result", result, 0);
    chk("e2_err", res_err, 1);
    handshake("e2");

    // 9^6 = 531441 wraps to 7153
    send_str("9*9*9*9*9*9=");
    chk("e3_result", result, 7153);
    chk("e3_err", res_err, 0);
    handshake("e3");

    // Spaces ignored; result held while consumer stalls; '1' not taken meanwhile
    send_str("7 * 8 =");
    chk("e4_result", result, 56);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = "1";
    for (int i = 0; i < 3; i++) begin
      chk("e4_in_ready_stall", in_ready, 0);
      chk("e4_valid_stall", res_valid, 1);
      chk("e4_result_stall", result, 56);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("e4_valid_drop", res_valid, 0);
    chk("e4_busy_no_digit", busy, 0);
    chk("e4_result_hold", result, 56);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("e4_busy_digit", busy, 1);
    send("=");
    chk("e4_second_result", result, 1);
    chk("e4_second_err", res_err, 0);
    handshake("e4");

    // '=' right after an operator is malformed
    send_str("2+=");
    chk("e5_result", result, 0);
    chk("e5_err", res_err, 1);
    handshake("e5");

    // Reset mid-expression
    send_str("2+3");
    chk("e6_busy_mid", busy, 1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("e6_rst_busy", busy, 0);
    chk("e6_rst_result", result, 0);
    chk("e6_rst_in_ready", in_ready, 1);
    @(negedge clk);
    clr = 1'b1;
    send_str("8=");
    chk("e6_result", result, 8);
    chk("e6_err", res_err, 0);
    handshake("e6");

    // Reset while in REPORT
    send_str("5=");
    chk("e7_valid", res_valid, 1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("e7_rst_valid", res_valid, 0);
    chk("e7_rst_result", result, 0);
    @(negedge clk);
    clr = 1'b1;
    send_str("4*3+1*2=");
    chk("e7_result", result, 14);
    chk("e7_err", res_err, 0);
    handshake("e7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expr_seq.md
EXPR_SEQ -- requirements
Module: expr_seq

Interface
REQ-001 SHALL have parameter RW, default 16, result width in bits; legal range 8..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_data holds a character this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts a character this cycle.
REQ-006 SHALL have port in_data  input  8  ASCII character.
REQ-007 SHALL have port res_valid  output  1  result and res_err are valid.
REQ-008 SHALL have port res_ready  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port result  output  RW  evaluated value, modulo 2^RW.
REQ-010 SHALL have port res_err  output  1  expression was malformed.
REQ-011 SHALL have port busy  output  1  an expression is in progress or its result is awaiting the consumer.

Function
REQ-012 SHALL transfer a character only on a rising edge with in_valid=1 and in_ready=1; no other character SHALL affect state.
REQ-013 SHALL accept the grammar: digit ('+'|'*' digit)* '=', where digit is '0'..'9', and the space character (0x20) is ignored in every input state.
REQ-014 SHALL implement states EXP_NUM, EXP_OP, ERR and REPORT; reset state is EXP_NUM.
REQ-015 SHALL keep registers S (sum, RW bits), T (term, RW bits) and M (pending multiply, 1 bit), all zero in EXP_NUM before the first digit.
REQ-016 In EXP_NUM, a digit d SHALL set T=(M ? T*d : d) truncated to RW bits, clear M, and go to EXP_OP.
REQ-017 In EXP_OP, '+' SHALL set S=S+T (mod 2^RW) and T=0, and go to EXP_NUM.
REQ-018 In EXP_OP, '*' SHALL set M=1 and go to EXP_NUM; '*' SHALL bind tighter than '+'.
REQ-019 In EXP_OP, '=' SHALL load result=S+T (mod 2^RW), clear res_err, and go to REPORT.
REQ-020 Any other non-space character in EXP_NUM or EXP_OP, except '=' in EXP_NUM, SHALL go to ERR.
REQ-021 '=' in EXP_NUM SHALL load result=0 and res_err=1, and go to REPORT.
REQ-022 In ERR, SHALL accept and discard characters; '=' SHALL load result=0 and res_err=1, and go to REPORT.
REQ-023 in_ready SHALL be 1 in EXP_NUM, EXP_OP and ERR, and 0 in REPORT; it depends on state only.
REQ-024 res_valid SHALL be 1 exactly in REPORT, rising on the edge that accepts '=' (latency 1 cycle).
REQ-025 result and res_err SHALL stay stable while res_valid=1 and res_ready=0.
REQ-026 In REPORT, res_ready=1 SHALL return the block to EXP_NUM on that edge and clear S, T and M; result and res_err SHALL hold their values.
REQ-027 busy SHALL be 0 only in EXP_NUM with no digit accepted since the last reset or REPORT exit.
REQ-028 Arithmetic SHALL wrap silently at 2^RW; wrap SHALL NOT set res_err.

Reset
REQ-029 clr=0 SHALL immediately force state EXP_NUM and set S=T=M=0, result=0, res_err=0, res_valid=0 and busy=0, without waiting for clk.
REQ-030 On release of clr, in_ready SHALL read 1, and the first character accepted after release SHALL start a new expression, including after a reset taken mid-expression or in REPORT.

Verification
REQ-031 Stream "2+3*4=" with res_ready=1 -> res_valid for 1 cycle, result=14, res_err=0, busy=0 on the following cycle.
REQ-032 Stream "++3*45+3=" -> enters ERR on the first '+'; result=0, res_err=1.
REQ-033 RW=16, stream "9*9*9*9*9*9=" -> result=7153 (531441 mod 65536), res_err=0.
REQ-034 Stream "7 * 8 =" with res_ready=0 for 3 cycles -> result=56 held, in_ready=0 throughout, and a "1=" offered meanwhile is not consumed until after the handshake.
REQ-035 Stream "2+=" -> result=0, res_err=1; and "2+3" then clr pulse low for 1 cycle, then "8=" -> result=8, res_err=0.
